// File: rtl/elevator_car_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : elevator_pkg
// Shared encodings, FSM state type and hall-call bit mapping for the car.
// Revision: 1.0
// ============================================================================
package elevator_pkg;

    localparam logic OPEN  = 1'b1;
    localparam logic CLOSE = 1'b0;
    localparam logic ON    = 1'b1;
    localparam logic OFF   = 1'b0;
    localparam logic MOVE  = 1'b1;
    localparam logic HOLD  = 1'b0;

    localparam logic [1:0] STOP   = 2'b00;
    localparam logic [1:0] UP     = 2'b10;
    localparam logic [1:0] DOWN   = 2'b01;
    localparam logic [1:0] UPDOWN = 2'b11;

    localparam int NUM_FLOORS = 7;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVING    = 2'd1,
        S_DOOR_OPEN = 2'd2
    } state_t;

    // Floor f owns hall bits 2f-1 (UP) and 2f-2 (DOWN); f is 1..7.
    function automatic logic [3:0] up_bit(input logic [2:0] f);
        return {f, 1'b0} - 4'd1;
    endfunction

    function automatic logic [3:0] dn_bit(input logic [2:0] f);
        return {f, 1'b0} - 4'd2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_car_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : elevator_car_ctrl_if
// Request inputs, timebase and car status outputs of the car controller.
// Revision: 1.0
// ============================================================================
interface elevator_car_ctrl_if;

    logic        tick;
    logic [13:0] floorButton;
    logic [9:1]  internalButton;
    logic [2:0]  currentFloor;
    logic [1:0]  currentDirection;
    logic        doorState;
    logic        move;

    modport master (
        output tick, floorButton, internalButton,
        input  currentFloor, currentDirection, doorState, move
    );

    modport slave (
        input  tick, floorButton, internalButton,
        output currentFloor, currentDirection, doorState, move
    );

endinterface
`default_nettype wire

// File: rtl/elevator_car_ctrl_request_scan.sv
`default_nettype none
// ============================================================================
// Module  : request_scan
// Summarises pending requests relative to one floor (here / above / below).
// Revision: 1.0
// ============================================================================
module request_scan
    import elevator_pkg::*;
(
    input  wire logic [2:0]  i_floor,
    input  wire logic [13:0] i_floor_button,
    input  wire logic [7:1]  i_car_call,
    output logic             o_here,
    output logic             o_above,
    output logic             o_below,
    output logic             o_hall_up_here,
    output logic             o_hall_dn_here
);

    logic [7:0] w_up;
    logic [7:0] w_dn;
    logic [7:0] w_here_v;

    assign w_up[0] = 1'b0;
    assign w_dn[0] = 1'b0;

    for (genvar f = 1; f <= NUM_FLOORS; f++) begin : g_hall
        assign w_up[f] = i_floor_button[up_bit(3'(f))];
        assign w_dn[f] = i_floor_button[dn_bit(3'(f))];
    end

    assign w_here_v       = w_up | w_dn | {i_car_call, 1'b0};
    assign o_here         = w_here_v[i_floor];
    assign o_hall_up_here = w_up[i_floor];
    assign o_hall_dn_here = w_dn[i_floor];

    // Masks keep floors strictly above / strictly below i_floor.
    assign o_above = |(w_here_v & ~((8'd2 << i_floor) - 8'd1));
    assign o_below = |(w_here_v & ((8'd1 << i_floor) - 8'd1));

endmodule
`default_nettype wire

// File: rtl/elevator_car_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : elevator_car_ctrl
// SCAN car-motion controller: direction, travel timing, stops and door timing.
// Revision: 1.0
// ============================================================================
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int TRAVEL_TICKS = 4,
    parameter int DOOR_TICKS   = 3,
    parameter int CNT_W        = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    elevator_car_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] C_TRAVEL = CNT_W'(TRAVEL_TICKS);
    localparam logic [CNT_W-1:0] C_DOOR   = CNT_W'(DOOR_TICKS);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    state_t           r_state;
    logic [2:0]       r_floor;
    logic [1:0]       r_dir;
    logic             r_door;
    logic             r_move;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hall_prev;

    logic w_here_c, w_above_c, w_below_c, w_up_c, w_dn_c;
    logic w_here_n, w_above_n, w_below_n, w_up_n, w_dn_n;
    logic [2:0] w_next_floor;
    logic [7:0] w_car_vec;
    logic       w_car_n, w_beyond, w_at_edge, w_dir_hall_n, w_opp_hall_n, w_stop;
    logic [1:0] w_stop_dir;
    logic       w_hall_dir_c, w_hall_new, w_go_up;

    request_scan u_scan_cur (
        .i_floor(r_floor), .i_floor_button(bus.floorButton),
        .i_car_call(bus.internalButton[7:1]),
        .o_here(w_here_c), .o_above(w_above_c), .o_below(w_below_c),
        .o_hall_up_here(w_up_c), .o_hall_dn_here(w_dn_c)
    );

    request_scan u_scan_nxt (
        .i_floor(w_next_floor), .i_floor_button(bus.floorButton),
        .i_car_call(bus.internalButton[7:1]),
        .o_here(w_here_n), .o_above(w_above_n), .o_below(w_below_n),
        .o_hall_up_here(w_up_n), .o_hall_dn_here(w_dn_n)
    );

    assign w_next_floor = (r_dir == UP   && r_floor != 3'(NUM_FLOORS)) ? r_floor + 3'd1 :
                          (r_dir == DOWN && r_floor != 3'd1)           ? r_floor - 3'd1 :
                                                                         r_floor;
    assign w_car_vec    = {bus.internalButton[7:1], 1'b0};
    assign w_car_n      = w_car_vec[w_next_floor];
    assign w_beyond     = (r_dir == UP) ? w_above_n : (r_dir == DOWN) ? w_below_n : 1'b0;
    assign w_at_edge    = (r_dir == UP   && w_next_floor == 3'(NUM_FLOORS)) ||
                          (r_dir == DOWN && w_next_floor == 3'd1);
    // A hall call pointing off the end of the shaft never keeps the direction alive.
    assign w_dir_hall_n = ((r_dir == UP) ? w_up_n : (r_dir == DOWN) ? w_dn_n : 1'b0) & ~w_at_edge;
    assign w_opp_hall_n = (r_dir == UP) ? w_dn_n : (r_dir == DOWN) ? w_up_n : 1'b0;
    assign w_stop       = w_car_n | w_dir_hall_n | (~w_beyond & w_here_n) | w_at_edge;
    assign w_stop_dir   = (w_beyond | w_dir_hall_n) ? r_dir :
                          w_opp_hall_n              ? ~r_dir : STOP;

    assign w_hall_dir_c = (r_dir == UP) ? w_up_c : (r_dir == DOWN) ? w_dn_c : 1'b0;
    assign w_hall_new   = w_hall_dir_c & ~r_hall_prev;
    assign w_go_up      = w_above_c & ~(r_dir == DOWN && w_below_c);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_floor     <= 3'd1;
            r_dir       <= STOP;
            r_door      <= CLOSE;
            r_move      <= HOLD;
            r_cnt       <= '0;
            r_hall_prev <= 1'b0;
        end else if (bus.tick) begin
            r_hall_prev <= w_hall_dir_c;
            case (r_state)
                S_IDLE: begin
                    if (bus.internalButton[8] || w_here_c) begin
                        r_state     <= S_DOOR_OPEN;
                        r_door      <= OPEN;
                        r_cnt       <= C_DOOR;
                        r_hall_prev <= 1'b1;
                    end else if (w_go_up || w_below_c) begin
                        r_dir   <= w_go_up ? UP : DOWN;
                        r_state <= S_MOVING;
                        r_move  <= MOVE;
                        r_cnt   <= C_TRAVEL;
                    end else begin
                        r_dir <= STOP;
                    end
                end
                S_MOVING: begin
                    if (r_cnt > C_ONE) begin
                        r_cnt <= r_cnt - C_ONE;
                    end else begin
                        r_floor <= w_next_floor;
                        if (w_stop) begin
                            r_state     <= S_DOOR_OPEN;
                            r_move      <= HOLD;
                            r_door      <= OPEN;
                            r_cnt       <= C_DOOR;
                            r_dir       <= w_stop_dir;
                            r_hall_prev <= 1'b1;
                        end else begin
                            r_cnt <= C_TRAVEL;
                        end
                    end
                end
                S_DOOR_OPEN: begin
                    // Open request is tested first so it beats a simultaneous close.
                    if (bus.internalButton[8] || w_hall_new) begin
                        r_cnt <= C_DOOR;
                    end else if (bus.internalButton[9] || r_cnt <= C_ONE) begin
                        r_cnt   <= '0;
                        r_door  <= CLOSE;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.currentFloor     = r_floor;
    assign bus.currentDirection = r_dir;
    assign bus.doorState        = r_door;
    assign bus.move             = r_move;

endmodule
`default_nettype wire

// File: tb/tb_elevator_car_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_elevator_car_ctrl
// Directed self-checking bench for elevator_car_ctrl.
// Revision: 1.0
// ============================================================================
module tb_elevator_car_ctrl;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    elevator_car_ctrl_if ifc ();

    elevator_car_ctrl #(
        .TRAVEL_TICKS(4),
        .DOOR_TICKS  (3),
        .CNT_W       (4)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One tick per call; requests at the current floor are cleared while the
    // door is open, standing in for the button-latch block.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ifc.tick = 1'b1;
            @(negedge clk) ifc.tick = 1'b0;
            if (ifc.doorState) begin
                for (int f = 1; f <= 7; f++) begin
                    if (ifc.currentFloor == 3'(f)) begin
                        ifc.internalButton[f] = 1'b0;
                        ifc.floorButton[2*f-1] = 1'b0;
                        ifc.floorButton[2*f-2] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ifc.tick = 1'b0;
        ifc.floorButton = '0;
        ifc.internalButton = '0;
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        ifc.tick = 1'b0;
        ifc.floorButton = '0;
        ifc.internalButton = '0;
        repeat (2) @(negedge clk);
        chk("rst_floor", 32'(ifc.currentFloor), 1);
        chk("rst_dir",   32'(ifc.currentDirection), 0);
        chk("rst_door",  32'(ifc.doorState), 0);
        chk("rst_move",  32'(ifc.move), 0);
        reset = 1'b0;

        // 1: car call to floor 5
        ifc.internalButton[5] = 1'b1;
        tick_n(1);
        chk("t1_dir_up", 32'(ifc.currentDirection), 2);
        chk("t1_move",   32'(ifc.move), 1);
        tick_n(15);
        chk("t1_floor4", 32'(ifc.currentFloor), 4);
        tick_n(1);
        chk("t1_floor5", 32'(ifc.currentFloor), 5);
        chk("t1_door",   32'(ifc.doorState), 1);
        chk("t1_hold",   32'(ifc.move), 0);
        chk("t1_stop",   32'(ifc.currentDirection), 0);
        tick_n(2);
        chk("t1_door_held", 32'(ifc.doorState), 1);
        tick_n(1);
        chk("t1_door_shut", 32'(ifc.doorState), 0);
        tick_n(1);
        chk("t1_idle_dir",  32'(ifc.currentDirection), 0);
        chk("t1_idle_move", 32'(ifc.move), 0);

        // 6: timebase stalled mid-travel
        ifc.internalButton[3] = 1'b1;
        tick_n(1);
        chk("t6_dir_dn", 32'(ifc.currentDirection), 1);
        tick_n(2);
        repeat (20) @(negedge clk);
        chk("t6_floor_held", 32'(ifc.currentFloor), 5);
        chk("t6_move_held",  32'(ifc.move), 1);
        chk("t6_dir_held",   32'(ifc.currentDirection), 1);
        tick_n(1);
        chk("t6_floor_still5", 32'(ifc.currentFloor), 5);
        tick_n(1);
        chk("t6_floor4", 32'(ifc.currentFloor), 4);
        chk("t6_pass4",  32'(ifc.move), 1);
        tick_n(1);

        // 5: asynchronous reset between floors 4 and 3
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5_floor", 32'(ifc.currentFloor), 1);
        chk("t5_dir",   32'(ifc.currentDirection), 0);
        chk("t5_door",  32'(ifc.doorState), 0);
        chk("t5_move",  32'(ifc.move), 0);
        ifc.internalButton = '0;
        @(negedge clk) reset = 1'b0;

        // 2: pass a down call on the way up, serve it afterwards
        do_reset();
        ifc.internalButton[6] = 1'b1;
        tick_n(9);
        chk("t2_floor3", 32'(ifc.currentFloor), 3);
        ifc.floorButton[6] = 1'b1;
        tick_n(4);
        chk("t2_floor4",  32'(ifc.currentFloor), 4);
        chk("t2_pass4",   32'(ifc.move), 1);
        chk("t2_closed4", 32'(ifc.doorState), 0);
        tick_n(8);
        chk("t2_floor6", 32'(ifc.currentFloor), 6);
        chk("t2_door6",  32'(ifc.doorState), 1);
        tick_n(3);
        chk("t2_shut6", 32'(ifc.doorState), 0);
        tick_n(1);
        chk("t2_dir_dn", 32'(ifc.currentDirection), 1);
        chk("t2_move_dn", 32'(ifc.move), 1);
        tick_n(8);
        chk("t2_floor4b", 32'(ifc.currentFloor), 4);
        chk("t2_door4",   32'(ifc.doorState), 1);
        chk("t2_dir4",    32'(ifc.currentDirection), 1);
        tick_n(4);
        chk("t2_final_dir", 32'(ifc.currentDirection), 0);

        // 3: door-open hold, open+close, then close
        do_reset();
        ifc.internalButton[2] = 1'b1;
        tick_n(5);
        chk("t3_floor2", 32'(ifc.currentFloor), 2);
        chk("t3_open",   32'(ifc.doorState), 1);
        for (int i = 0; i < 4; i++) begin
            ifc.internalButton[8] = 1'b1;
            tick_n(1);
            ifc.internalButton[8] = 1'b0;
            chk("t3_hold_open", 32'(ifc.doorState), 1);
        end
        tick_n(2);
        chk("t3_still_open", 32'(ifc.doorState), 1);
        ifc.internalButton[8] = 1'b1;
        ifc.internalButton[9] = 1'b1;
        tick_n(1);
        ifc.internalButton[8] = 1'b0;
        ifc.internalButton[9] = 1'b0;
        chk("t3_open_wins", 32'(ifc.doorState), 1);
        tick_n(1);
        chk("t3_open_after", 32'(ifc.doorState), 1);
        ifc.internalButton[9] = 1'b1;
        tick_n(1);
        ifc.internalButton[9] = 1'b0;
        chk("t3_close", 32'(ifc.doorState), 0);

        // 4: top floor with only up(7)
        do_reset();
        ifc.floorButton[13] = 1'b1;
        tick_n(24);
        chk("t4_floor6", 32'(ifc.currentFloor), 6);
        chk("t4_moving", 32'(ifc.move), 1);
        tick_n(1);
        chk("t4_floor7", 32'(ifc.currentFloor), 7);
        chk("t4_door7",  32'(ifc.doorState), 1);
        chk("t4_dir7",   32'(ifc.currentDirection), 0);
        tick_n(4);
        chk("t4_floor_end", 32'(ifc.currentFloor), 7);
        chk("t4_move_end",  32'(ifc.move), 0);
        chk("t4_door_end",  32'(ifc.doorState), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
